adder_ring_meter: RTL and testbench

//   Measurement sequencer downstream of the instrumented Kogge-Stone adder.

---
 rtl/adder_ring_meter.sv | 181 ++++++++++++++++++
 tb/tb_adder_ring_meter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_ring_meter.sv
// -----------------------------------------------------------------------------
// adder_ring_meter
//   Measurement sequencer for the instrumented Kogge-Stone adder ring.
//   On an accepted start it enables the ring oscillator. It lets the ring
//   settle, then counts rising edges of the synchronised chain_out over a
//   programmed window of clock cycles. After that it disables the ring and
//   drains the synchroniser. Finally it reports the count with a one-cycle
//   done pulse.
//
// Ports
//   wb_clk_i   in   1      clock, all logic on rising edge
//   wb_rst_i   in   1      synchronous reset, active-high
//   start      in   1      measurement request, honoured only when idle
//   window     in   WIN_W  measurement length in cycles, latched on start
//   ring_in    in   1      asynchronous chain_out from the adder
//   ring_en    out  1      ring oscillator enable
//   busy       out  1      high while settling, measuring or draining
//   done       out  1      one-cycle pulse, count_out/overflow valid
//   count_out  out  CNT_W  saturating edge count of the last run
//   overflow   out  1      sticky per run: an edge arrived at full count
// -----------------------------------------------------------------------------
module adder_ring_meter #(
  parameter int WIN_W       = 24,
  parameter int CNT_W       = 32,
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             ring_in,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow
);

  // The phase timer must hold the window length as well as the settle and
  // drain lengths.
  localparam int SHORT_W = $clog2(SETTLE_CYC + SYNC_STAGES + 2);
  localparam int TMR_W   = (WIN_W > SHORT_W) ? WIN_W : SHORT_W;

  // The timer counts down to zero, so each phase loads (length - 1).
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(SYNC_STAGES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ring_en_q, ring_en_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_det;

  // Synchroniser stage boundary: ring_in -> sync_q -> prev_q
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ring_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    ring_en_d = ring_en_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          if (window != '0) begin
            win_d     = window;
            tmr_d     = SETTLE_LD;
            ring_en_d = 1'b1;
            state_d   = S_SETTLE;
          end else begin
            // An empty window never runs the ring.
            state_d = S_DONE;
          end
        end
      end

      S_SETTLE: begin
        if (tmr_q == '0) begin
          tmr_d   = TMR_W'(win_q) - TMR_W'(1);
          state_d = S_MEASURE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_MEASURE: begin
        if (edge_det) begin
          if (cnt_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (tmr_q == '0) begin
          tmr_d     = DRAIN_LD;
          ring_en_d = 1'b0;
          state_d   = S_DRAIN;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_DRAIN: begin
        // Edges still in flight through the synchroniser are discarded.
        if (tmr_q == '0) begin
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        ring_en_d = 1'b0;
      end
    endcase
  end

  // Control stage boundary
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ring_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ring_en_q <= ring_en_d;
    end
  end

  // Window latch is pure data and is always written before use.
  always_ff @(posedge wb_clk_i) begin
    win_q <= win_d;
  end

  assign ring_en   = ring_en_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_MEASURE) ||
                     (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign count_out = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_ring_meter.sv
module tb_adder_ring_meter;

  localparam int WIN_W = 24;
  localparam int SET   = 16;
  localparam int S     = 2;
  localparam int HMAX  = 16384;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIN_W-1:0] window;
  logic             ring_in;

  logic        re8, busy8, done8, ovf8;
  logic [7:0]  cnt8;
  logic        re32, busy32, done32, ovf32;
  logic [31:0] cnt32;

  adder_ring_meter #(.WIN_W(WIN_W), .CNT_W(8), .SETTLE_CYC(SET), .SYNC_STAGES(S)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .window(window), .ring_in(ring_in),
    .ring_en(re8), .busy(busy8), .done(done8), .count_out(cnt8), .overflow(ovf8)
  );

  adder_ring_meter #(.WIN_W(WIN_W), .CNT_W(32), .SETTLE_CYC(SET), .SYNC_STAGES(S)) dut32 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .window(window), .ring_in(ring_in),
    .ring_en(re32), .busy(busy32), .done(done32), .count_out(cnt32), .overflow(ovf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is described only by its start cycle and window; all outputs are
  // derived from those plus the recorded ring_in history.
  int   cyc       = 0;
  logic hist [0:HMAX-1];
  bit   run_valid = 0;
  int   t0        = 0;
  int   w_run     = 0;

  function automatic int done_cycle();
    if (w_run == 0) return t0 + 1;
    return t0 + SET + w_run + S + 2;
  endfunction

  // A rising edge on ring_in between cycles k-S-1 and k-S is seen in cycle k.
  function automatic int edge_at(input int k);
    if (k - S - 1 < 0) return 0;
    return (hist[k-S] && !hist[k-S-1]) ? 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      begin
        int n;
        n = cyc;
        hist[n] = ring_in;
        if (rst) begin
          run_valid = 0;
        end else if (start && (!run_valid || n > done_cycle())) begin
          run_valid = 1;
          t0        = n;
          w_run     = int'(window);
        end
        cyc = n + 1;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        int c, raw, e_re, e_busy, e_done, hi;
        c = cyc;
        raw = 0; e_re = 0; e_busy = 0; e_done = 0;
        if (run_valid) begin
          if (w_run == 0) begin
            e_done = (c == t0 + 1) ? 1 : 0;
          end else begin
            e_re   = (c >= t0 + 1 && c <= t0 + SET + w_run) ? 1 : 0;
            e_busy = (c >= t0 + 1 && c <= t0 + SET + w_run + S + 1) ? 1 : 0;
            e_done = (c == done_cycle()) ? 1 : 0;
            hi = (c - 1 < t0 + SET + w_run) ? c - 1 : t0 + SET + w_run;
            for (int k = t0 + SET + 1; k <= hi; k++) raw += edge_at(k);
          end
        end
        chk("ring_en8", re8, e_re);
        chk("ring_en32", re32, e_re);
        chk("busy8", busy8, e_busy);
        chk("busy32", busy32, e_busy);
        chk("done8", done8, e_done);
        chk("done32", done32, e_done);
        chk("count8", cnt8, (raw > 255) ? 255 : raw);
        chk("overflow8", ovf8, (raw > 255) ? 1 : 0);
        chk("count32", cnt32, raw);
        chk("overflow32", ovf32, 0);
      end
    end
  end

  // ---------------- ring_in generator ----------------
  int ring_mode = 0;   // 0: low, 1: period 4, 2: period 2
  logic [31:0] ph = '0;
  initial begin
    ring_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = ph + 1;
      case (ring_mode)
        1:       ring_in = ph[1];
        2:       ring_in = ph[0];
        default: ring_in = 1'b0;
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input int w);
    start  = 1'b1;
    window = WIN_W'(w);
    tick();
    start  = 1'b0;
  endtask

  // Called in the first cycle after the start cycle; lat is the number of
  // cycles from the start cycle to the cycle where done is seen.
  task automatic wait_done(input int max, output int lat, output int re_cnt,
                           output int busy_cnt);
    lat = 1; re_cnt = 0; busy_cnt = 0;
    while (!done32 && lat < max) begin
      re_cnt   += int'(re32);
      busy_cnt += int'(busy32);
      tick();
      lat++;
    end
    re_cnt   += int'(re32);
    busy_cnt += int'(busy32);
  endtask

  int lat, rec, bc, nd;

  initial begin
    rst = 1'b1; start = 1'b0; window = '0;
    repeat (5) tick();
    rst = 1'b0;
    chk("reset count", cnt32, 0);
    chk("reset busy", busy32, 0);
    chk("reset ring_en", re32, 0);
    chk("reset overflow", ovf32, 0);
    repeat (3) tick();

    // T1: ring quiet
    run_start(100);
    wait_done(300, lat, rec, bc);
    chk("T1 latency", lat, 120);
    chk("T1 count", cnt32, 0);
    chk("T1 overflow", ovf32, 0);
    chk("T1 ring_en cycles", rec, 116);
    tick();

    // T2: period-4 square wave
    ring_mode = 1;
    repeat (5) tick();
    run_start(100);
    wait_done(300, lat, rec, bc);
    chk("T2 latency", lat, 120);
    chk("T2 count in 24..26", (cnt32 >= 24 && cnt32 <= 26) ? 1 : 0, 1);
    chk("T2 ring_en cycles", rec, 116);
    chk("T2 busy cycles", bc, 119);
    tick();

    // T3: saturation in the 8-bit counter, then a clean run clears it
    ring_mode = 2;
    repeat (3) tick();
    run_start(1000);
    wait_done(1200, lat, rec, bc);
    chk("T3 latency", lat, 1020);
    chk("T3 count8", cnt8, 255);
    chk("T3 overflow8", ovf8, 1);
    chk("T3 count32", cnt32, 500);
    ring_mode = 0;
    repeat (5) tick();
    run_start(50);
    wait_done(200, lat, rec, bc);
    chk("T3b count8", cnt8, 0);
    chk("T3b overflow8", ovf8, 0);
    tick();

    // T4: empty window
    run_start(0);
    wait_done(10, lat, rec, bc);
    chk("T4 latency", lat, 1);
    chk("T4 ring_en cycles", rec, 0);
    chk("T4 busy cycles", bc, 0);
    chk("T4 count", cnt32, 0);
    tick();
    chk("T4 done width", done32, 0);
    tick();

    // T5: start held high throughout, window changed mid-run
    start  = 1'b1;
    window = WIN_W'(50);
    tick();
    lat = 1;
    while (!done32 && lat < 200) begin
      if (lat == 10) window = WIN_W'(7);
      tick();
      lat++;
    end
    chk("T5 latency", lat, 70);
    tick();                 // start stayed high through the done cycle
    start  = 1'b0;
    window = '0;
    nd = 0;
    repeat (30) begin
      nd += int'(done32);
      tick();
    end
    chk("T5 extra done pulses", nd, 0);
    chk("T5 busy after", busy32, 0);

    // T6: reset ten cycles into the measurement
    ring_mode = 1;
    run_start(100);
    repeat (26) tick();
    chk("T6 busy before reset", busy32, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("T6 ring_en after reset", re32, 0);
    chk("T6 busy after reset", busy32, 0);
    chk("T6 count after reset", cnt32, 0);
    nd = 0;
    repeat (100) begin
      nd += int'(done32);
      tick();
    end
    chk("T6 no done", nd, 0);
    run_start(20);
    wait_done(200, lat, rec, bc);
    chk("T6 fresh latency", lat, 40);
    chk("T6 fresh count in 4..6", (cnt32 >= 4 && cnt32 <= 6) ? 1 : 0, 1);
    ring_mode = 0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
